// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: fetch FSM states, jump-control condition
// encodings and flag-bit ordering.
package kgp_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_HOLD   = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   typedef enum logic [2:0] {
      JC_NONE = 3'b000,
      JC_BLTZ = 3'b001,
      JC_BZ   = 3'b010,
      JC_BNZ  = 3'b011,
      JC_BCY  = 3'b100,
      JC_BNCY = 3'b101
   } jc_cond_e;

   // Flag vector is packed {carry, zero, sign}.
   localparam int FLAG_SIGN  = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_CARRY = 2;

   typedef struct packed {
      logic carry;
      logic zero;
      logic sign;
   } flags_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selector: register jump, then PC-relative
// (unconditional or taken branch), then sequential. All sums wrap.
module pc_next
   import kgp_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 22
) (
   input  logic [ADDR_W-1:0] instr_pc,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic [ADDR_W-1:0] rs_val,
   input  logic              reg_jump,
   input  logic              uncond,
   input  logic              br_taken,
   output logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] seq_pc
);

   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] rel_target;

   assign off_ext    = {{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
   assign rel_target = instr_pc + off_ext;
   assign seq_pc     = instr_pc + ADDR_W'(1);

   always_comb begin
      if (reg_jump)
         next_pc = rs_val;
      else if (uncond || br_taken)
         next_pc = rel_target;
      else
         next_pc = seq_pc;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// KGP-RISC PC and instruction-fetch stage: one req/ack fetch per instruction,
// held for decode until retirement selects the next PC.
module pc_fetch_unit
   import kgp_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                OFF_W    = 22,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              exec_done,
   input  logic              br_taken,
   input  logic              uncond,
   input  logic              link,
   input  logic              reg_jump,
   input  logic              halt,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic [ADDR_W-1:0] rs_val,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data,
   output logic              halted,
   output logic [31:0]       retire_count
);

   fetch_state_e      state_q, state_d;
   logic              req_q, req_d;
   logic              link_we_q, link_we_d;
   logic              halted_q, halted_d;
   logic [ADDR_W-1:0] pc_q, instr_pc_q, link_data_q;
   logic [31:0]       instr_q, retire_count_q;
   logic              valid_q;
   logic              fetch_accept, retire;
   logic [ADDR_W-1:0] next_pc, seq_pc;

   // Ack counts only while a request is actually on the bus in FETCH.
   assign fetch_accept = (state_q == ST_FETCH) && req_q && imem_ack;
   assign retire       = (state_q == ST_HOLD) && exec_done;

   pc_next #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_pc_next (
      .instr_pc  (instr_pc_q),
      .br_offset (br_offset),
      .rs_val    (rs_val),
      .reg_jump  (reg_jump),
      .uncond    (uncond),
      .br_taken  (br_taken),
      .next_pc   (next_pc),
      .seq_pc    (seq_pc)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_FETCH;
      else        state_q <= state_d;
   end

   // NOTE: default-assign first so no path through the case leaves state_d
   // unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_FETCH:  if (fetch_accept) state_d = ST_HOLD;
         ST_HOLD:   if (exec_done)    state_d = halt ? ST_HALTED : ST_FETCH;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      req_d     = (state_d == ST_FETCH);
      link_we_d = retire && link && uncond;
      halted_d  = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q          <= 1'b0;
         link_we_q      <= 1'b0;
         halted_q       <= 1'b0;
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         instr_pc_q     <= '0;
         valid_q        <= 1'b0;
         link_data_q    <= '0;
         retire_count_q <= '0;
      end else begin
         req_q     <= req_d;
         link_we_q <= link_we_d;
         halted_q  <= halted_d;
         if (fetch_accept) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
         end
         if (retire) begin
            pc_q           <= next_pc;
            valid_q        <= 1'b0;
            retire_count_q <= retire_count_q + 32'd1;
            if (link && uncond) link_data_q <= seq_pc;
         end
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign instr_valid  = valid_q;
   assign link_we      = link_we_q;
   assign link_data    = link_data_q;
   assign halted       = halted_q;
   assign retire_count = retire_count_q;

endmodule
